// File: rtl/inst_encoder_if.sv
// inst_encoder_if
// Bundles the two valid/ready channels of the instruction encoder.
//   Input channel  : in_valid, in_ready, in_opcode, in_rd, in_rs1, in_rs2,
//                    in_funct3, in_funct7, in_imm
//   Output channel : out_valid, out_ready, out_inst, out_addr
// The master modport is the program-loader side: it drives the input fields
// and out_ready. The slave modport is the encoder itself.
interface inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder
// Builds RV32I instruction words from decoded fields and a full 32-bit
// immediate, rejecting illegal opcodes, misaligned or out-of-range immediates.
// Each legal word is emitted with an incrementing byte address through a
// single registered output stage.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   addr_clr        returns the address counter to BASE_ADDR
//   bus             inst_encoder_if.slave: input fields and output word channels
//   err_valid       one-cycle pulse when an accepted input was rejected
//   err_code        0 none, 1 range, 2 alignment, 3 illegal opcode (sticky)
//   err_count       saturating count of rejections
//   inst_count      wrapping count of words taken downstream
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 addr_clr,
    inst_encoder_if.slave        bus,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [31:0]          inst_count
);

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_S,
        CLS_B,
        CLS_U,
        CLS_J,
        CLS_BAD
    } inst_class_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_ALIGN   = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_kind_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    inst_class_t       cls;
    err_kind_t         chk;
    logic [31:0]       enc;
    logic              accept;
    logic              legal;
    logic              out_fire;
    logic [ADDR_W-1:0] addr_base;
    logic              fits_i;
    logic              fits_b;
    logic              fits_j;

    logic              out_valid_q;
    logic [31:0]       out_inst_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] addr_cnt;

    // Handshake: a new word may enter whenever the output register is empty
    // or is being drained on this same edge.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign out_fire      = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;

    // addr_clr takes effect for the input accepted in the same cycle.
    assign addr_base = addr_clr ? BASE_ADDR : addr_cnt;

    // Sign-extension checks: every bit above the encodable field must match
    // the field's sign bit.
    assign fits_i = (bus.in_imm[31:11] == {21{bus.in_imm[31]}});
    assign fits_b = (bus.in_imm[31:12] == {20{bus.in_imm[31]}});
    assign fits_j = (bus.in_imm[31:20] == {12{bus.in_imm[31]}});

    // Opcode class decode; anything without the 32-bit '11' suffix or with an
    // unlisted major opcode is illegal.
    always_comb begin
        cls = CLS_BAD;
        case (bus.in_opcode[6:2])
            5'b01100:                   cls = CLS_R;
            5'b00000, 5'b00100, 5'b11001: cls = CLS_I;
            5'b01000:                   cls = CLS_S;
            5'b11000:                   cls = CLS_B;
            5'b01101, 5'b00101:         cls = CLS_U;
            5'b11011:                   cls = CLS_J;
            default:                    cls = CLS_BAD;
        endcase
        if (bus.in_opcode[1:0] != 2'b11) begin
            cls = CLS_BAD;
        end
    end

    // Immediate scatter and legality check. Within a class, alignment faults
    // are tested before range faults so the higher-priority code wins.
    always_comb begin
        enc = '0;
        chk = ERR_NONE;
        case (cls)
            CLS_R: begin
                enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_rd, bus.in_opcode};
            end
            CLS_I: begin
                enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                       bus.in_rd, bus.in_opcode};
                if (!fits_i) chk = ERR_RANGE;
            end
            CLS_S: begin
                enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_imm[4:0], bus.in_opcode};
                if (!fits_i) chk = ERR_RANGE;
            end
            CLS_B: begin
                enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                       bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11],
                       bus.in_opcode};
                if (bus.in_imm[0])   chk = ERR_ALIGN;
                else if (!fits_b)    chk = ERR_RANGE;
            end
            CLS_U: begin
                enc = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
                if (bus.in_imm[11:0] != 12'd0) chk = ERR_ALIGN;
            end
            CLS_J: begin
                enc = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                       bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
                if (bus.in_imm[0])   chk = ERR_ALIGN;
                else if (!fits_j)    chk = ERR_RANGE;
            end
            default: begin
                chk = ERR_ILLEGAL;
            end
        endcase
    end

    assign legal = (chk == ERR_NONE);

    // Output stage: a legal accept loads a new word (even while the previous
    // one is being drained), otherwise a completed handshake empties it.
    // Rejected inputs leave the held word untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= BASE_ADDR;
        end else if (accept && legal) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= enc;
            out_addr_q  <= addr_base;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    // Address counter: advances only for legal words; addr_clr rewinds it
    // even when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= BASE_ADDR;
        end else if (accept && legal) begin
            addr_cnt <= addr_base + ADDR_STEP;
        end else if (addr_clr) begin
            addr_cnt <= BASE_ADDR;
        end
    end

    // Emitted-word counter, stepped when downstream takes a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count <= '0;
        end else if (out_fire) begin
            inst_count <= inst_count + 32'd1;
        end
    end

    // Error reporting: pulse plus sticky code and a saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            err_count <= '0;
        end else begin
            err_valid <= accept && !legal;
            if (accept && !legal) begin
                err_code <= chk;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
// Scoreboard bench for inst_encoder: stimulus pushes expected words/errors
// into queues, a monitor pops and compares them as the DUT presents them.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_clr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic [31:0] inst_count;

    inst_encoder_if #(.ADDR_W(32)) bus ();

    inst_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .ERR_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_clr   (addr_clr),
        .bus        (bus),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_count  (err_count),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } word_t;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] count;
    } err_t;

    word_t       exp_q[$];
    err_t        err_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [7:0]  exp_err_count = 8'h0;
    int          legal_sent = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one set of fields until accepted and record what should follow.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic [1:0] exp_err,
                                 input logic [31:0] exp_inst);
        logic acc;
        int   waited;
        if (exp_err == 2'd0) begin
            exp_q.push_back('{inst: exp_inst, addr: exp_addr});
            exp_addr = exp_addr + 32'd4;
            legal_sent++;
        end else begin
            if (exp_err_count != 8'hFF) exp_err_count = exp_err_count + 8'd1;
            err_q.push_back('{code: exp_err, count: exp_err_count});
        end
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        waited = 0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, bounded.
    task automatic waitDrain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && err_q.size() == 0) break;
        end
        checkOutput("drain_words", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_errs", 32'(err_q.size()), 32'd0);
    endtask

    // Monitor: compare every handshaken word and every error pulse.
    initial begin
        word_t w;
        err_t  e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got %h expected none", bus.out_inst);
                    end else begin
                        w = exp_q.pop_front();
                        checkOutput("out_inst", bus.out_inst, w.inst);
                        checkOutput("out_addr", bus.out_addr, w.addr);
                    end
                end
                if (err_valid) begin
                    if (err_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_err: got code %0d expected none", err_code);
                    end else begin
                        e = err_q.pop_front();
                        checkOutput("err_code", 32'(err_code), 32'(e.code));
                        checkOutput("err_count", 32'(err_count), 32'(e.count));
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        addr_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_inst", bus.out_inst, 32'd0);
        checkOutput("rst_out_addr", bus.out_addr, 32'd0);
        checkOutput("rst_err_valid", 32'(err_valid), 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_inst_count", inst_count, 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed single instructions, legal and rejected.
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        2'd0, 32'h00500093);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 2'd0, 32'hFE000EE3);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        2'd0, 32'h008000EF);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 2'd0, 32'h123452B7);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 2'd2, 32'h0);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     2'd1, 32'h0);
        applyStimulus(7'b0000010, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        2'd3, 32'h0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 2'd0, 32'h402081B3);
        applyStimulus(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        2'd0, 32'h0020A423);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 2'd0, 32'h80000093);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     2'd0, 32'h7FF00093);
        applyStimulus(7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 2'd0, 32'h00001117);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        2'd2, 32'h0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,     2'd1, 32'h0);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 2'd1, 32'h0);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00001, 2'd2, 32'h0);
        applyStimulus(7'b1101110, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        2'd3, 32'h0);
        applyStimulus(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        2'd3, 32'h0);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 2'd0, 32'h800000EF);
        waitDrain();
        checkOutput("inst_count_directed", inst_count, 32'(legal_sent));

        // Reset while a word is held: the word must be discarded.
        bus.out_ready = 1'b0;
        applyStimulus(7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 2'd0, 32'h00900493);
        checkOutput("held_before_rst", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_addr      = 32'h0;
        exp_err_count = 8'h0;
        legal_sent    = 0;
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_out_addr", bus.out_addr, 32'd0);
        checkOutput("mid_rst_inst_count", inst_count, 32'd0);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        checkOutput("mid_rst_err_code", 32'(err_code), 32'd0);
        bus.out_ready = 1'b1;

        // Stream of four with a three-cycle stall after the first word.
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 2'd0, 32'h00100093);
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("hold_inst", bus.out_inst, 32'h00100093);
                    checkOutput("hold_addr", bus.out_addr, 32'h0);
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join_none
        applyStimulus(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 2'd0, 32'h00200113);
        applyStimulus(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 2'd0, 32'h00300193);
        applyStimulus(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 2'd0, 32'h00400213);
        waitDrain();
        checkOutput("inst_count_stream", inst_count, 32'd4);

        // addr_clr together with an accept rewinds to the base address.
        applyStimulus(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 2'd0, 32'h00500293);
        addr_clr = 1'b1;
        exp_addr = 32'h0;
        applyStimulus(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 2'd0, 32'h00600313);
        addr_clr = 1'b0;
        applyStimulus(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 2'd0, 32'h00700393);
        waitDrain();
        checkOutput("inst_count_final", inst_count, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
